// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle mul/div hold, perf counters.
// Latency: control outputs are combinational from state and inputs (zero cycles); counters update on the next edge.
// Backpressure: stalls drop PCWrite/IFIDWrite; mul/div holds the front end for MULDIV_LAT cycles total.
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        BranchTaken,
    input  logic        MulDivStart,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        EXMEMBubble,
    output logic        Busy,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // The first stall cycle is spent in RUN, so MD_WAIT covers the remaining MULDIV_LAT-1 cycles
    // by counting md_cnt down from MULDIV_LAT-2 to 0 inclusive.
    localparam bit         MD_MULTI = (MULDIV_LAT > 1);
    localparam logic [7:0] MD_INIT  = MD_MULTI ? 8'(MULDIV_LAT - 2) : 8'd0;

    state_t      state_q, state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_use;
    logic        branch_evt;

    assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    // Priority decode of the pipeline controls and next FSM state; everything is held low in reset.
    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        Busy        = 1'b0;
        branch_evt  = 1'b0;
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        if (!Reset) begin
            unique case (state_q)
                RUN: begin
                    if (BranchTaken) begin
                        // Taken branch wins: squash the wrong-path IF and ID contents, keep fetching.
                        PCWrite    = 1'b1;
                        IFIDWrite  = 1'b1;
                        IDEXWrite  = 1'b1;
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                        branch_evt = 1'b1;
                    end else if (MulDivStart) begin
                        EXMEMBubble = 1'b1;
                        if (MD_MULTI) begin
                            state_d  = MD_WAIT;
                            md_cnt_d = MD_INIT;
                        end
                    end else if (load_use) begin
                        // Hold IF/ID one cycle and push a bubble into EX; the bubble clears MemRead.
                        IDEXWrite  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDWrite = 1'b1;
                        IDEXWrite = 1'b1;
                    end
                end
                MD_WAIT: begin
                    EXMEMBubble = 1'b1;
                    Busy        = 1'b1;
                    if (md_cnt_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - 8'd1;
                    end
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (branch_evt && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have parameter MULDIV_LAT, default 4, meaning total stall cycles per multiply/divide op (legal range 1..255).
REQ-002 The module SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port IDEX_MemRead, input, 1, meaning the instruction in EX is a load.
REQ-005 The module SHALL have port IDEX_Rt, input, 5, meaning the load destination register in EX.
REQ-006 The module SHALL have ports IFID_Rs and IFID_Rt, input, 5 each, meaning the source registers of the instruction in ID.
REQ-007 The module SHALL have port IFID_UsesRt, input, 1, meaning the ID instruction reads Rt.
REQ-008 The module SHALL have port BranchTaken, input, 1, meaning a branch/jump resolved taken in EX.
REQ-009 The module SHALL have port MulDivStart, input, 1, meaning a mul/div op entered EX this cycle.
REQ-010 The module SHALL have ports PCWrite, IFIDWrite and IDEXWrite, output, 1 each, meaning the write enables of the PC, IF/ID and ID/EX registers.
REQ-011 The module SHALL have ports IFIDFlush, IDEXBubble and EXMEMBubble, output, 1 each, meaning zero the stage contents on the next edge.
REQ-012 The module SHALL have port Busy, output, 1, meaning the module is in the MD_WAIT state.
REQ-013 The module SHALL have ports StallCount and FlushCount, output, 16 each, meaning performance counters.

Function
REQ-014 The module SHALL implement states RUN and MD_WAIT, plus an 8-bit down-counter md_cnt.
REQ-015 Control outputs SHALL be combinational from the current state and inputs, giving zero-cycle latency.
REQ-016 In RUN, the first matching rule SHALL apply, in priority order: BranchTaken > MulDivStart > load-use > normal.
REQ-017 Branch: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=1, IDEXBubble=1, EXMEMBubble=0; a simultaneous MulDivStart or load-use SHALL be ignored; FlushCount SHALL increment.
REQ-018 MulDivStart: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1; if MULDIV_LAT>1, next state MD_WAIT with md_cnt<=MULDIV_LAT-2; if MULDIV_LAT=1, stay in RUN.
REQ-019 Load-use hazard SHALL be the condition IDEX_MemRead & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
REQ-020 On a load-use hazard: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXBubble=1, other outputs 0; the stall SHALL last exactly one cycle because the bubble clears IDEX_MemRead.
REQ-021 Normal: PCWrite=IFIDWrite=IDEXWrite=1; IFIDFlush=IDEXBubble=EXMEMBubble=0.
REQ-022 In MD_WAIT: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1, Busy=1; all other inputs SHALL be ignored; md_cnt SHALL decrement each cycle; at md_cnt==0 the next state SHALL be RUN.
REQ-023 Total PCWrite=0 cycles per MulDivStart SHALL equal MULDIV_LAT exactly.
REQ-024 StallCount SHALL increment on every cycle with PCWrite=0 and Reset=0.
REQ-025 Both counters SHALL saturate at 16'hFFFF with no wrap-around.
REQ-026 The module SHALL NOT generate IFIDFlush=1 together with IFIDWrite=0.

Reset
REQ-027 While Reset=1, all control outputs SHALL be 0 and Busy SHALL be 0.
REQ-028 On a rising edge with Reset=1: state<=RUN, md_cnt<=0, StallCount<=0, FlushCount<=0.
REQ-029 Reset SHALL take effect from any state, including mid-MD_WAIT.
REQ-030 In the first cycle after Reset deasserts, the module SHALL be in RUN with normal outputs (given no hazard inputs).

Verification
REQ-031 Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 that cycle; StallCount=1.
REQ-032 Zero register: same stimulus with IDEX_Rt=0, IFID_Rs=0 -> no stall. IFID_Rt=5 with IFID_UsesRt=0 -> no stall.
REQ-033 MulDiv: MulDivStart=1 for 1 cycle, MULDIV_LAT=4 -> PCWrite=0 for exactly 4 consecutive cycles; Busy=1 on cycles 2-4; StallCount=4; then RUN.
REQ-034 Priority: BranchTaken=1 together with a load-use hazard and MulDivStart -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; FlushCount=1; StallCount unchanged; state stays RUN.
REQ-035 Reset mid-operation: Reset=1 on the 2nd MD_WAIT cycle -> next cycle state=RUN, Busy=0, StallCount=0, FlushCount=0.
REQ-036 Saturation: force 70000 load-use cycles -> StallCount holds 16'hFFFF.
